// File: rtl/rx_pkg.sv
// Shared types and default constants for the serial receive framer.
package rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        LOAD
    } rx_state_t;

    localparam int RX_CLKS_PER_BIT = 10;
    localparam int RX_DATA_BITS    = 8;

endpackage

// File: rtl/rx_bit_timer.sv
// Clock-per-bit counter producing a sample strobe at half or full bit period.
import rx_pkg::*;

module rx_bit_timer #(
    parameter int CLKS_PER_BIT = RX_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    input  logic half_i,
    output logic strobe_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] term;

    assign term     = half_i ? CNT_W'(CLKS_PER_BIT / 2 - 1) : CNT_W'(CLKS_PER_BIT - 1);
    assign strobe_o = en_i && (cnt_q == term);

    // The strobe reloads zero so the next bit period starts counting immediately.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = strobe_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_rx_framer.sv
// Serial frame receiver: start validation, LSB-first data capture, stop check,
// holding register with ready / framing-error / overrun flags.
import rx_pkg::*;

module serial_rx_framer #(
    parameter int CLKS_PER_BIT = RX_CLKS_PER_BIT,
    parameter int DATA_BITS    = RX_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    input  logic                 data_read,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 framing_error,
    output logic                 overrun_error,
    output logic                 rx_busy
);

    localparam int IDX_W = $clog2(DATA_BITS + 1);

    rx_state_t            state_q;
    logic                 prev_in_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [IDX_W-1:0]     bit_idx_q;
    logic                 stop_bit_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 data_ready_q;
    logic                 framing_error_q;
    logic                 overrun_error_q;
    logic                 busy_q;

    logic start_edge;
    logic tmr_clr;
    logic tmr_en;
    logic tmr_half;
    logic sample;

    assign start_edge = prev_in_q & ~serial_in;
    assign tmr_clr    = (state_q == IDLE) || (state_q == LOAD);
    assign tmr_en     = (state_q == START) || (state_q == DATA) || (state_q == STOP);
    assign tmr_half   = (state_q == START);

    rx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (tmr_clr),
        .en_i     (tmr_en),
        .half_i   (tmr_half),
        .strobe_o (sample)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            prev_in_q       <= 1'b1;
            shift_q         <= '0;
            bit_idx_q       <= '0;
            stop_bit_q      <= 1'b0;
            rx_data_q       <= '0;
            data_ready_q    <= 1'b0;
            framing_error_q <= 1'b0;
            overrun_error_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            prev_in_q <= serial_in;
            // A read clears ready; the LOAD branch below overrides this when coincident.
            if (data_read) begin
                data_ready_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (start_edge) begin
                        state_q <= START;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (sample) begin
                        if (!serial_in) begin
                            state_q   <= DATA;
                            bit_idx_q <= '0;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (sample) begin
                        shift_q   <= {serial_in, shift_q[DATA_BITS-1:1]};
                        bit_idx_q <= bit_idx_q + 1'b1;
                        if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
                            state_q <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (sample) begin
                        stop_bit_q <= serial_in;
                        state_q    <= LOAD;
                    end
                end
                LOAD: begin
                    rx_data_q       <= shift_q;
                    framing_error_q <= ~stop_bit_q;
                    overrun_error_q <= data_ready_q & ~data_read;
                    data_ready_q    <= 1'b1;
                    state_q         <= IDLE;
                    busy_q          <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data       = rx_data_q;
    assign data_ready    = data_ready_q;
    assign framing_error = framing_error_q;
    assign overrun_error = overrun_error_q;
    assign rx_busy       = busy_q;

endmodule

// File: tb/tb_serial_rx_framer.sv
// Self-checking bench for serial_rx_framer at CLKS_PER_BIT=10, DATA_BITS=8.
module tb_serial_rx_framer;

    logic       clk = 1'b0;
    logic       rst;
    logic       serial_in;
    logic       data_read;
    logic [7:0] rx_data;
    logic       data_ready;
    logic       framing_error;
    logic       overrun_error;
    logic       rx_busy;

    int total = 0;
    int bad   = 0;

    serial_rx_framer #(
        .CLKS_PER_BIT (10),
        .DATA_BITS    (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .serial_in     (serial_in),
        .data_read     (data_read),
        .rx_data       (rx_data),
        .data_ready    (data_ready),
        .framing_error (framing_error),
        .overrun_error (overrun_error),
        .rx_busy       (rx_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       read_before;
        logic       read_on_load;
        logic [7:0] exp_rx;
        logic       exp_rdy;
        logic       exp_fe;
        logic       exp_ov;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_read();
        @(posedge clk); #1 data_read = 1'b1;
        @(posedge clk); #1 data_read = 1'b0;
    endtask

    // Line falls just after edge 0; bit slot s covers the edges 10*s+1 .. 10*s+10.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic rol,
                              output int rdy_edge);
        logic [9:0] bits;
        bits     = {stop, d, 1'b0};
        rdy_edge = -1;
        @(posedge clk); #1 serial_in = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (rdy_edge < 0 && data_ready) rdy_edge = n;
            data_read = rol && (n == 96);
            serial_in = (n == 100) ? 1'b1 : bits[n / 10];
        end
    endtask

    vec_t       vecs [6];
    int         edge_n;
    logic [9:0] ff_bits;
    logic       ready_m, fe_m, ov_m;
    logic [7:0] rx_m;
    logic [7:0] rd;
    logic       rs, rb, rl;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'h55, 1'b1, 1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h11, 1'b1, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h22, 1'b1, 1'b0, 1'b0, 8'h22, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{8'h33, 1'b1, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0};

        rst       = 1'b1;
        serial_in = 1'b1;
        data_read = 1'b0;
        #12;
        check("reset rx_data", rx_data, 0);
        check("reset ready", data_ready, 0);
        check("reset fe", framing_error, 0);
        check("reset ov", overrun_error, 0);
        check("reset busy", rx_busy, 0);
        @(negedge clk) rst = 1'b0;
        repeat (3) @(posedge clk);

        // Start glitch: low for 3 cycles, then high before mid-bit validation.
        @(posedge clk); #1 serial_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("glitch busy during start", rx_busy, 1);
        serial_in = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("glitch busy after", rx_busy, 0);
        repeat (20) @(posedge clk);
        #1 check("glitch ready", data_ready, 0);
        check("glitch busy idle", rx_busy, 0);

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].read_before) pulse_read();
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].read_on_load, edge_n);
            if (i == 0) check("first frame latency", edge_n, 97);
            check($sformatf("vec%0d rx_data", i), rx_data, vecs[i].exp_rx);
            check($sformatf("vec%0d ready", i), data_ready, vecs[i].exp_rdy);
            check($sformatf("vec%0d fe", i), framing_error, vecs[i].exp_fe);
            check($sformatf("vec%0d ov", i), overrun_error, vecs[i].exp_ov);
            check($sformatf("vec%0d busy", i), rx_busy, 0);
        end

        // Reset during data bit 4 of 0xFF.
        ff_bits = {1'b1, 8'hFF, 1'b0};
        @(posedge clk); #1 serial_in = 1'b0;
        for (int n = 1; n <= 54; n++) begin
            @(posedge clk); #1 serial_in = ff_bits[n / 10];
        end
        check("midframe busy", rx_busy, 1);
        rst = 1'b1;
        #1;
        check("midrst rx_data", rx_data, 0);
        check("midrst ready", data_ready, 0);
        check("midrst fe", framing_error, 0);
        check("midrst ov", overrun_error, 0);
        check("midrst busy", rx_busy, 0);
        @(posedge clk); #1 rst = 1'b0;
        serial_in = 1'b1;
        repeat (60) @(posedge clk);
        #1 check("post rst idle ready", data_ready, 0);
        send_frame(8'h81, 1'b1, 1'b0, edge_n);
        check("post rst latency", edge_n, 97);
        check("post rst rx_data", rx_data, 8'h81);
        check("post rst fe", framing_error, 0);
        check("post rst ov", overrun_error, 0);

        // Break: line stuck low for 200 cycles.
        pulse_read();
        @(posedge clk); #1 serial_in = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        check("break rx_data", rx_data, 0);
        check("break ready", data_ready, 1);
        check("break fe", framing_error, 1);
        check("break ov", overrun_error, 0);
        pulse_read();
        repeat (100) @(posedge clk);
        #1;
        check("break no refire ready", data_ready, 0);
        check("break no refire busy", rx_busy, 0);
        serial_in = 1'b1;
        repeat (2) @(posedge clk);

        // Random frames against a flag-level model.
        ready_m = 1'b0;
        rx_m    = 8'h00;
        fe_m    = 1'b1;
        ov_m    = 1'b0;
        for (int i = 0; i < 24; i++) begin
            rd = 8'($urandom_range(0, 255));
            rs = ($urandom_range(0, 3) != 0);
            rb = 1'($urandom_range(0, 1));
            rl = ($urandom_range(0, 3) == 0);
            if (rb) begin
                pulse_read();
                ready_m = 1'b0;
            end
            send_frame(rd, rs, rl, edge_n);
            ov_m    = ready_m && !rl;
            ready_m = 1'b1;
            rx_m    = rd;
            fe_m    = !rs;
            check($sformatf("rnd%0d rx_data", i), rx_data, rx_m);
            check($sformatf("rnd%0d ready", i), data_ready, ready_m);
            check($sformatf("rnd%0d fe", i), framing_error, fe_m);
            check($sformatf("rnd%0d ov", i), overrun_error, ov_m);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_rx_framer.md
Name: serial_rx_framer

Overview:
- Consumes the synchronized, idle-high serial line from the two-flop input synchronizer.
- Per frame: detects the start bit, validates it at mid-bit, samples DATA_BITS data bits LSB-first at bit centres, then checks the stop bit.
- Presents each received byte in a holding register, with ready, framing-error and overrun flags, to the downstream register/bus interface.

Parameters:
- CLKS_PER_BIT, 10, clk cycles per serial bit; must be at least 4 and even.
- DATA_BITS, 8, data bits per frame; range 5..8.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; one clock; reset is asynchronous and active-high.
- serial_in  input  1  synchronized serial line; idle = 1.
- data_read  input  1  one-cycle pulse from consumer; acknowledges rx_data.
- rx_data  output  DATA_BITS  last received byte, LSB = first bit on the wire.
- data_ready  output  1  rx_data holds an unread byte.
- framing_error  output  1  stop bit of the last frame sampled as 0.
- overrun_error  output  1  a frame completed while data_ready=1 and no data_read arrived.
- rx_busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst=1):
  - rx_data=0, data_ready=0, framing_error=0, overrun_error=0, rx_busy=0.
  - State=IDLE, counters=0, shift register=0.
  - prev_in=1, consistent with the synchronizer's idle-high reset.
- Edge detect: prev_in <= serial_in every cycle. start_edge = prev_in & ~serial_in.
- IDLE:
  - On start_edge: go to START, bit_cnt_clk<=0.
  - A line held low with no preceding high never starts a frame.
- START:
  - bit_cnt_clk counts up each cycle.
  - When bit_cnt_clk==CLKS_PER_BIT/2-1, sample serial_in.
  - Sample 0: go to DATA, bit_cnt_clk<=0, bit_idx<=0.
  - Sample 1: treat as a glitch; go to IDLE with no flag change.
- DATA:
  - When bit_cnt_clk==CLKS_PER_BIT-1: shift serial_in into the MSB of the shift register (right shift), bit_cnt_clk<=0, bit_idx++.
  - After sampling bit DATA_BITS-1, go to STOP.
  - For DATA_BITS<8, the shift register is DATA_BITS wide, so the result is already LSB-aligned.
- STOP:
  - When bit_cnt_clk==CLKS_PER_BIT-1, latch stop_bit=serial_in and go to LOAD.
- LOAD (one cycle):
  - rx_data<=shift register.
  - framing_error<=~stop_bit.
  - overrun_error<=data_ready & ~data_read; sticky-updated: set on overrun, otherwise keeps its value until the next LOAD.
  - data_ready<=1. Then go to IDLE.
  - A framing-error frame still loads rx_data and sets data_ready.
- data_read:
  - Clears data_ready at the next edge when not in LOAD.
  - Coincident with LOAD: data_ready stays 1, rx_data updates, no overrun.
  - data_read while data_ready=0 has no effect.
- Overrun: the older byte is overwritten; newest data wins.
- Latency at CLKS_PER_BIT=10, DATA_BITS=8:
  - start_edge detected at edge k.
  - START entered k+1; DATA entered k+6; data bits sampled at k+16, k+26, …, k+86.
  - Stop bit sampled at k+96.
  - Outputs valid after edge k+97.
- Back-to-back frames: a new start_edge is accepted in the first IDLE cycle after LOAD. The stop bit's high level provides prev_in=1.
- Break (line stuck low through stop):
  - framing_error=1, rx_data=0.
  - Receiver then stays in IDLE until the line returns high and falls again.
- rst asserted mid-frame: immediate return to reset values; the partial frame is discarded.
- Counter widths: bit_cnt_clk is $clog2(CLKS_PER_BIT) bits, bit_idx is $clog2(DATA_BITS+1) bits. No wrap occurs in legal operation.

Decomposition:
- Shared package rx_pkg holds:
  - rx_state_t enum {IDLE, START, DATA, STOP, LOAD}.
  - Default constants RX_CLKS_PER_BIT=10 and RX_DATA_BITS=8.
- One sub-module: rx_bit_timer.
  - Loadable clock-per-bit counter, with clear, enable, and a terminal-count input selecting half or full period.
  - Outputs a sample strobe.
  - The framer FSM, shift register and flags stay in serial_rx_framer.

Test Plan (all at CLKS_PER_BIT=10, DATA_BITS=8):
- Single frame 0xA5, stop=1: rx_data=0xA5, data_ready=1 exactly 97 edges after start detection, framing_error=0, overrun_error=0, rx_busy low afterwards.
- Start glitch (line low 3 cycles, then high): no state beyond START, rx_busy returns 0 by cycle 6, data_ready stays 0.
- Frame 0x3C with stop bit=0: rx_data=0x3C, data_ready=1, framing_error=1. A following good frame 0x55 with data_read in between gives framing_error=0.
- Two frames 0x11 then 0x22 with no data_read: after the second, rx_data=0x22, overrun_error=1. A third frame 0x33 with data_read pulsed on its LOAD cycle gives rx_data=0x33, data_ready=1, overrun_error=0.
- rst pulsed during data bit 4 of frame 0xFF: all outputs at reset values. A following frame 0x81 receives correctly.
- Line held low 200 cycles from idle: one frame with rx_data=0x00 and framing_error=1, then no further data_ready until a fresh high-to-low edge.
